// File: rtl/warblade_pkg.sv
// -----------------------------------------------------------------------------
// warblade_pkg
// Shared constants for the Warblade game-state pipeline: screen and sprite
// geometry, the coordinate width and the per-frame update FSM encoding.
// Every coordinate is an unsigned 11-bit value (0..2047), which covers
// 1024x768 with headroom.
// -----------------------------------------------------------------------------
package warblade_pkg;

  localparam int COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;

  // Screen and sprite geometry, in pixels.
  localparam coord_t SCREEN_W    = 11'd1024;
  localparam coord_t SHIP_W      = 11'd64;
  localparam coord_t SHIP_Y      = 11'd680;
  localparam coord_t SHIP_STEP   = 11'd4;
  localparam coord_t BULLET_W    = 11'd4;
  localparam coord_t BULLET_H    = 11'd12;
  localparam coord_t BULLET_STEP = 11'd8;
  localparam coord_t ENEMY_W     = 11'd64;
  localparam coord_t ENEMY_H     = 11'd64;

  // Derived positions.
  localparam coord_t SHIP_X_MAX     = SCREEN_W - SHIP_W;               // 960
  localparam coord_t SHIP_X_RST     = (SCREEN_W - SHIP_W) >> 1;        // 480
  localparam coord_t SHIP_X_R_LIMIT = SHIP_X_MAX - SHIP_STEP;          // 956
  localparam coord_t BULLET_X_OFS   = (SHIP_W >> 1) - (BULLET_W >> 1); // 30
  localparam coord_t BULLET_Y_SPAWN = SHIP_Y - BULLET_H;               // 668

  // One update step per state, one state per clock.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SAMPLE      = 3'd1,
    ST_MOVE_SHIP   = 3'd2,
    ST_MOVE_BULLET = 3'd3,
    ST_CHECK_HIT   = 3'd4,
    ST_COMMIT      = 3'd5
  } state_t;

endpackage

// File: rtl/rect_overlap.sv
// -----------------------------------------------------------------------------
// rect_overlap
// Combinational axis-aligned bounding-box test of two rectangles given as
// top-left (x, y) plus width/height. The right and bottom edges are
// exclusive, so rectangles that only touch along an edge do not overlap.
// The edge sums are formed in COORD_W+1 bits so a sprite near the far edge
// of the coordinate range cannot wrap around and report a false overlap.
//
// Ports:
//   ax, ay, aw, ah  rectangle A position and size
//   bx, by, bw, bh  rectangle B position and size
//   overlap         1 when A and B share at least one pixel
// -----------------------------------------------------------------------------
module rect_overlap
  import warblade_pkg::*;
(
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] aw,
  input  logic [COORD_W-1:0] ah,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic [COORD_W-1:0] bw,
  input  logic [COORD_W-1:0] bh,
  output logic               overlap
);

  logic [COORD_W:0] a_right, a_bottom, b_right, b_bottom;

  assign a_right  = {1'b0, ax} + {1'b0, aw};
  assign a_bottom = {1'b0, ay} + {1'b0, ah};
  assign b_right  = {1'b0, bx} + {1'b0, bw};
  assign b_bottom = {1'b0, by} + {1'b0, bh};

  assign overlap = ({1'b0, ax} < b_right)  && ({1'b0, bx} < a_right) &&
                   ({1'b0, ay} < b_bottom) && ({1'b0, by} < a_bottom);

endmodule

// File: rtl/frame_update_ctrl.sv
// -----------------------------------------------------------------------------
// frame_update_ctrl
// Per-frame game-state scheduler. On each rising edge of vertical blanking it
// walks a short FSM (sample keys, move ship, move/spawn bullet, test the
// bullet against the enemy) on private working registers, then copies them
// to the output registers in a single COMMIT cycle. The draw stages therefore
// never see a half-updated frame, and outputs only change during blanking.
//
// Ports:
//   pclk          pixel clock
//   rst           asynchronous active-low reset
//   vblnk_in      vertical blank from vga_timing
//   key_left/right/fire  held-key levels, pclk-synchronous
//   enemy_x/y     enemy top-left corner, sampled only in CHECK_HIT
//   enemy_alive   enemy takes part in the hit test
//   ship_xpos/ypos      committed ship position (ypos is fixed)
//   bullet_x/y/active   committed bullet state
//   hit           one-cycle pulse at COMMIT when the bullet struck the enemy
//   busy          high from SAMPLE through COMMIT
//   frame_cnt     number of completed updates, wraps at 16 bits
// -----------------------------------------------------------------------------
module frame_update_ctrl
  import warblade_pkg::*;
(
  input  logic               pclk,
  input  logic               rst,
  input  logic               vblnk_in,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               key_fire,
  input  logic [COORD_W-1:0] enemy_x,
  input  logic [COORD_W-1:0] enemy_y,
  input  logic               enemy_alive,
  output logic [COORD_W-1:0] ship_xpos,
  output logic [COORD_W-1:0] ship_ypos,
  output logic [COORD_W-1:0] bullet_x,
  output logic [COORD_W-1:0] bullet_y,
  output logic               bullet_active,
  output logic               hit,
  output logic               busy,
  output logic [15:0]        frame_cnt
);

  state_t state;
  logic   vblnk_prev;
  logic   fire_prev, fire_edge;
  logic   lat_left, lat_right;

  // Working copies; only COMMIT moves them to the outputs.
  coord_t wx, bx, by;
  logic   ba, hit_w;

  logic vblnk_rise;
  logic bullet_enemy_ovl;
  logic hit_now;

  assign vblnk_rise = vblnk_in & ~vblnk_prev;
  assign ship_ypos  = SHIP_Y;

  rect_overlap u_bullet_enemy (
    .ax      (bx),
    .ay      (by),
    .aw      (BULLET_W),
    .ah      (BULLET_H),
    .bx      (enemy_x),
    .by      (enemy_y),
    .bw      (ENEMY_W),
    .bh      (ENEMY_H),
    .overlap (bullet_enemy_ovl)
  );

  assign hit_now = ba & enemy_alive & bullet_enemy_ovl;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below reads the value from before this clock edge.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      vblnk_prev    <= 1'b1;   // no false vblnk edge straight out of reset
      fire_prev     <= 1'b0;
      fire_edge     <= 1'b0;
      lat_left      <= 1'b0;
      lat_right     <= 1'b0;
      wx            <= SHIP_X_RST;
      bx            <= '0;
      by            <= '0;
      ba            <= 1'b0;
      hit_w         <= 1'b0;
      ship_xpos     <= SHIP_X_RST;
      bullet_x      <= '0;
      bullet_y      <= '0;
      bullet_active <= 1'b0;
      hit           <= 1'b0;
      busy          <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      vblnk_prev <= vblnk_in;
      // NOTE: default first, overridden later in the same block; the last
      // non-blocking assignment wins, which makes hit a one-cycle pulse.
      hit        <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (vblnk_rise) begin
            state <= ST_SAMPLE;
            busy  <= 1'b1;
          end
        end

        ST_SAMPLE: begin
          lat_left  <= key_left;
          lat_right <= key_right;
          fire_edge <= key_fire & ~fire_prev;
          fire_prev <= key_fire;
          state     <= ST_MOVE_SHIP;
        end

        ST_MOVE_SHIP: begin
          // Both keys together cancel out.
          if (lat_left && !lat_right) begin
            wx <= (wx < SHIP_STEP) ? '0 : wx - SHIP_STEP;
          end else if (lat_right && !lat_left) begin
            wx <= (wx > SHIP_X_R_LIMIT) ? SHIP_X_MAX : wx + SHIP_STEP;
          end
          state <= ST_MOVE_BULLET;
        end

        ST_MOVE_BULLET: begin
          // A fire edge while a bullet is in flight is simply dropped.
          if (ba) begin
            if (by < BULLET_STEP) ba <= 1'b0;
            else                  by <= by - BULLET_STEP;
          end else if (fire_edge) begin
            ba <= 1'b1;
            bx <= wx + BULLET_X_OFS;
            by <= BULLET_Y_SPAWN;
          end
          state <= ST_CHECK_HIT;
        end

        ST_CHECK_HIT: begin
          hit_w <= hit_now;
          if (hit_now) ba <= 1'b0;
          state <= ST_COMMIT;
        end

        ST_COMMIT: begin
          ship_xpos     <= wx;
          bullet_x      <= bx;
          bullet_y      <= by;
          bullet_active <= ba;
          hit           <= hit_w;
          frame_cnt     <= frame_cnt + 16'd1;
          busy          <= 1'b0;
          state         <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_update_ctrl
// Directed and randomized frames against a frame-level behavioural model of
// the game rules (ship clamp, bullet flight, AABB hit on integers). Keys and
// enemy inputs are scrambled outside the cycles where the design may sample
// them, so any sampling at the wrong time shows up as a wrong result.
// -----------------------------------------------------------------------------
module tb_frame_update_ctrl;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic        vblnk_in = 1'b0;
  logic        key_left = 1'b0, key_right = 1'b0, key_fire = 1'b0;
  logic [10:0] enemy_x = '0, enemy_y = '0;
  logic        enemy_alive = 1'b0;
  logic [10:0] ship_xpos, ship_ypos, bullet_x, bullet_y;
  logic        bullet_active, hit, busy;
  logic [15:0] frame_cnt;

  frame_update_ctrl dut (
    .pclk          (pclk),
    .rst           (rst),
    .vblnk_in      (vblnk_in),
    .key_left      (key_left),
    .key_right     (key_right),
    .key_fire      (key_fire),
    .enemy_x       (enemy_x),
    .enemy_y       (enemy_y),
    .enemy_alive   (enemy_alive),
    .ship_xpos     (ship_xpos),
    .ship_ypos     (ship_ypos),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .bullet_active (bullet_active),
    .hit           (hit),
    .busy          (busy),
    .frame_cnt     (frame_cnt)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_errors = 0;

  // Frame-level reference model.
  int m_x, m_bx, m_by, m_cnt;
  bit m_ba, m_fire_prev, m_hit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 480; m_bx = 0; m_by = 0; m_ba = 1'b0;
    m_fire_prev = 1'b0; m_cnt = 0; m_hit = 1'b0;
  endtask

  task automatic model_frame(input bit l, input bit r, input bit f,
                             input int ex, input int ey, input bit ea);
    bit fe;
    fe = f && !m_fire_prev;
    m_fire_prev = f;
    if (l && !r) m_x = (m_x >= 4) ? m_x - 4 : 0;
    if (r && !l) m_x = (m_x + 4 <= 960) ? m_x + 4 : 960;
    if (m_ba) begin
      if (m_by < 8) m_ba = 1'b0;
      else          m_by = m_by - 8;
    end else if (fe) begin
      m_ba = 1'b1;
      m_bx = m_x + 30;
      m_by = 668;
    end
    m_hit = m_ba && ea && (m_bx < ex + 64) && (ex < m_bx + 4) &&
            (m_by < ey + 64) && (ey < m_by + 12);
    if (m_hit) m_ba = 1'b0;
    m_cnt = (m_cnt + 1) % 65536;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_ship_x"},   32'(ship_xpos),     480);
    check({pfx, "_ship_y"},   32'(ship_ypos),     680);
    check({pfx, "_bullet_x"}, 32'(bullet_x),      0);
    check({pfx, "_bullet_y"}, 32'(bullet_y),      0);
    check({pfx, "_bullet_a"}, 32'(bullet_active), 0);
    check({pfx, "_hit"},      32'(hit),           0);
    check({pfx, "_busy"},     32'(busy),          0);
    check({pfx, "_cnt"},      32'(frame_cnt),     0);
  endtask

  task automatic check_all(input string pfx);
    check({pfx, "_ship_x"},   32'(ship_xpos),     m_x);
    check({pfx, "_ship_y"},   32'(ship_ypos),     680);
    check({pfx, "_bullet_x"}, 32'(bullet_x),      m_bx);
    check({pfx, "_bullet_y"}, 32'(bullet_y),      m_by);
    check({pfx, "_bullet_a"}, 32'(bullet_active), 32'(m_ba));
    check({pfx, "_cnt"},      32'(frame_cnt),     m_cnt);
  endtask

  task automatic scramble_keys();
    key_left  = 1'($urandom_range(0, 1));
    key_right = 1'($urandom_range(0, 1));
    key_fire  = 1'($urandom_range(0, 1));
  endtask

  task automatic scramble_enemy();
    enemy_x     = 11'($urandom_range(0, 2047));
    enemy_y     = 11'($urandom_range(0, 2047));
    enemy_alive = 1'($urandom_range(0, 1));
  endtask

  // One full vblank update followed by a short stretch of active video.
  // Edges are counted from the first pclk edge that sees vblnk_in high.
  task automatic run_frame(input bit l, input bit r, input bit f,
                           input int ex, input int ey, input bit ea);
    int old_x, old_cnt;
    old_x   = m_x;
    old_cnt = m_cnt;
    model_frame(l, r, f, ex, ey, ea);
    @(negedge pclk);
    key_left = l; key_right = r; key_fire = f;
    vblnk_in = 1'b1;
    scramble_enemy();
    for (int e = 1; e <= 7; e++) begin
      @(posedge pclk); #1;
      case (e)
        1: begin
          check("busy_start", 32'(busy), 1);
          check("x_hold_e1", 32'(ship_xpos), old_x);
        end
        5: begin
          check("x_hold_e5", 32'(ship_xpos), old_x);
          check("cnt_hold_e5", 32'(frame_cnt), old_cnt);
          check("hit_early", 32'(hit), 0);
        end
        6: begin
          check_all("commit");
          check("hit", 32'(hit), 32'(m_hit));
          check("busy_done", 32'(busy), 0);
        end
        7: check("hit_pulse_end", 32'(hit), 0);
        default: ;
      endcase
      @(negedge pclk);
      if (e >= 2) scramble_keys();
      if (e == 4) begin
        enemy_x = 11'(ex); enemy_y = 11'(ey); enemy_alive = ea;
      end else begin
        scramble_enemy();
      end
    end
    vblnk_in = 1'b0;
    repeat (6) begin
      @(negedge pclk);
      scramble_keys();
      scramble_enemy();
    end
    check("x_active", 32'(ship_xpos), m_x);
    check("by_active", 32'(bullet_y), m_by);
    check("busy_active", 32'(busy), 0);
  endtask

  initial begin
    int ex, ey;
    bit rl, rr, rf, ra;

    // Reset.
    model_reset();
    #2 rst = 1'b0;
    repeat (3) @(negedge pclk);
    check_reset_vals("rst");
    rst = 1'b1;
    repeat (3) @(negedge pclk);
    check("no_false_start", 32'(busy), 0);

    // Two idle frames.
    repeat (2) run_frame(0, 0, 0, 0, 0, 0);
    check("idle_cnt", 32'(frame_cnt), 2);
    check("idle_x", 32'(ship_xpos), 480);

    // Left three frames: 476, 472, 468.
    run_frame(1, 0, 0, 0, 0, 0);
    check("left1", 32'(ship_xpos), 476);
    run_frame(1, 0, 0, 0, 0, 0);
    run_frame(1, 0, 0, 0, 0, 0);
    check("left3", 32'(ship_xpos), 468);

    // Left clamp at 0, right clamp at 960, both keys cancel.
    repeat (120) run_frame(1, 0, 0, 0, 0, 0);
    check("clamp_left", 32'(ship_xpos), 0);
    repeat (242) run_frame(0, 1, 0, 0, 0, 0);
    check("clamp_right", 32'(ship_xpos), 960);
    run_frame(1, 1, 0, 0, 0, 0);
    check("both_keys", 32'(ship_xpos), 960);

    // Back to x=480 and fire with no enemy.
    repeat (120) run_frame(1, 0, 0, 0, 0, 0);
    check("back_mid", 32'(ship_xpos), 480);
    run_frame(0, 0, 1, 0, 0, 0);
    check("spawn_x", 32'(bullet_x), 510);
    check("spawn_y", 32'(bullet_y), 668);
    check("spawn_a", 32'(bullet_active), 1);
    run_frame(0, 0, 1, 0, 0, 0);            // fire held: no respawn
    check("fly1", 32'(bullet_y), 660);
    run_frame(0, 0, 0, 0, 0, 0);
    run_frame(0, 0, 1, 0, 0, 0);            // new press while active: dropped
    check("fly3", 32'(bullet_y), 644);
    repeat (80) run_frame(0, 0, 0, 0, 0, 0);
    check("top_y", 32'(bullet_y), 4);
    check("top_a", 32'(bullet_active), 1);
    run_frame(0, 0, 0, 0, 0, 0);
    check("expire_a", 32'(bullet_active), 0);
    run_frame(0, 0, 1, 0, 0, 0);
    check("respawn_x", 32'(bullet_x), 510);
    check("respawn_y", 32'(bullet_y), 668);

    // Let it fly off, then fire into a live enemy at (500,640).
    repeat (84) run_frame(0, 0, 0, 0, 0, 0);
    check("cleared", 32'(bullet_active), 0);
    run_frame(0, 0, 1, 500, 640, 1);
    check("hit_expected", 32'(m_hit), 1);
    check("hit_kills", 32'(bullet_active), 0);
    run_frame(0, 0, 0, 500, 640, 1);
    run_frame(0, 0, 1, 600, 640, 1);
    check("miss_alive", 32'(bullet_active), 1);

    // Reset in the MOVE_BULLET cycle of an update with ship movement.
    @(negedge pclk);
    key_left = 1'b1; key_right = 1'b0; key_fire = 1'b0;
    vblnk_in = 1'b1;
    repeat (3) @(posedge pclk);
    #1 rst = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge pclk);
    rst = 1'b1;
    model_reset();
    repeat (5) begin
      @(negedge pclk);
      check("midrst_idle", 32'(busy), 0);
    end
    vblnk_in = 1'b0;
    repeat (3) @(negedge pclk);
    check("midrst_cnt", 32'(frame_cnt), 0);
    run_frame(0, 1, 0, 0, 0, 0);
    check("after_rst_x", 32'(ship_xpos), 484);
    check("after_rst_cnt", 32'(frame_cnt), 1);

    // Randomized frames, enemy often placed near the bullet.
    repeat (300) begin
      rl = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 2) == 0);
      rf = ($urandom_range(0, 2) == 0);
      ra = ($urandom_range(0, 3) != 0);
      ex = int'($urandom_range(0, 960));
      ey = int'($urandom_range(0, 700));
      if (m_ba && $urandom_range(0, 1) == 1) begin
        ex = (m_bx > 40) ? m_bx - 40 + int'($urandom_range(0, 50)) : int'($urandom_range(0, 50));
        ey = (m_by > 70) ? m_by - 70 + int'($urandom_range(0, 80)) : int'($urandom_range(0, 80));
      end
      run_frame(rl, rr, rf, ex, ey, ra);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
